// File: rtl/bcd_pkg.sv
// Shared definitions for the binary-to-BCD conversion scheduler:
// FSM state encoding, default widths, clamp limit and blank digit code.
package bcd_pkg;

    localparam int DEF_WIDTH  = 14;
    localparam int DEF_DIGITS = 4;
    localparam int MAX_VAL    = 9999;
    localparam int SHIFT_W    = DEF_WIDTH + 4 * DEF_DIGITS;

    // Digit code the segment decoder renders as an unlit digit
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: every BCD digit field that is 5 or more gets
// 3 added, then the whole register shifts left by one bit. Purely
// combinational; the caller registers the result once per clock.
module bcd_dabble_step
    import bcd_pkg::*;
#(
    parameter int SRW = SHIFT_W,    // total register width
    parameter int LSB = DEF_WIDTH   // bit index of the lowest digit field
) (
    input  logic [SRW-1:0] din,
    output logic [SRW-1:0] dout
);

    localparam int NDIG = (SRW - LSB) / 4;

    logic [SRW-1:0] adj;

    // Adjust each digit field, then shift the adjusted register
    always_comb begin
        // NOTE: give every combinational output a full default first so no
        // path through the block leaves it unassigned and infers a latch.
        adj = din;
        for (int d = 0; d < NDIG; d++) begin
            if (din[LSB + 4*d +: 4] >= 4'd5) begin
                adj[LSB + 4*d +: 4] = din[LSB + 4*d +: 4] + 4'd3;
            end
        end
        dout = {adj[SRW-2:0], 1'b0};
    end

endmodule

// File: rtl/bcd_conv_sched.sv
// Round-robin binary-to-BCD conversion scheduler for two value sources.
// A granted value is clamped to 9999 and converted by a sequential
// double-dabble, one add-3/shift step per clock, into four registered digits.
// Build option: define BCD_BLANK_EN to replace leading zero digits with the
// blank code when the result is latched (ones is never blanked).
module bcd_conv_sched
    import bcd_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DIGITS = DEF_DIGITS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req,
    input  logic [WIDTH-1:0] value0,
    input  logic [WIDTH-1:0] value1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [3:0]       thousands,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic             ovf
);

    localparam int SRW   = WIDTH + 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] CLAMP     = WIDTH'(MAX_VAL);

`ifdef BCD_BLANK_EN
    localparam bit BLANK_ON = 1'b1;
`else
    localparam bit BLANK_ON = 1'b0;
`endif

    state_t           state;
    logic [SRW-1:0]   sr;
    logic [SRW-1:0]   sr_next;
    logic [CNT_W-1:0] cnt;
    logic             prio;       // source that wins when both request
    logic             ovf_pend;   // clamp flag of the conversion in flight
    logic             id_pend;    // source of the conversion in flight

    logic             sel;
    logic [WIDTH-1:0] raw;
    logic             over;
    logic [WIDTH-1:0] clamped;

    logic [3:0]       d3, d2, d1, d0;
    logic [3:0]       o3, o2, o1, o0;

    bcd_dabble_step #(
        .SRW (SRW),
        .LSB (WIDTH)
    ) u_step (
        .din  (sr),
        .dout (sr_next)
    );

    // Pick the granted source and clamp its value to the displayable range
    always_comb begin
        sel = prio;
        if (req == 2'b01) begin
            sel = 1'b0;
        end else if (req == 2'b10) begin
            sel = 1'b1;
        end
        raw     = sel ? value1 : value0;
        over    = (raw > CLAMP);
        clamped = over ? CLAMP : raw;
    end

    // Digits after the final step, with optional leading-zero blanking
    always_comb begin
        d3 = sr_next[WIDTH + 12 +: 4];
        d2 = sr_next[WIDTH + 8  +: 4];
        d1 = sr_next[WIDTH + 4  +: 4];
        d0 = sr_next[WIDTH      +: 4];
        o3 = d3;
        o2 = d2;
        o1 = d1;
        o0 = d0;
        if (BLANK_ON && d3 == 4'd0) begin
            o3 = BLANK;
            if (d2 == 4'd0) begin
                o2 = BLANK;
                if (d1 == 4'd0) begin
                    o1 = BLANK;
                end
            end
        end
    end

    // Scheduler FSM: capture in IDLE, one dabble step per SHIFT cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sr        <= '0;
            cnt       <= '0;
            prio      <= 1'b0;
            ovf_pend  <= 1'b0;
            id_pend   <= 1'b0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            thousands <= 4'd0;
            hundreds  <= 4'd0;
            tens      <= 4'd0;
            ones      <= 4'd0;
            ovf       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register reading the
            // pre-edge values, so ordering inside this block does not matter.
            gnt  <= 2'b00;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        sr       <= {{(SRW - WIDTH){1'b0}}, clamped};
                        cnt      <= '0;
                        ovf_pend <= over;
                        id_pend  <= sel;
                        prio     <= ~sel;
                        gnt      <= sel ? 2'b10 : 2'b01;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr  <= sr_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST_STEP) begin
                        thousands <= o3;
                        hundreds  <= o2;
                        tens      <= o1;
                        ones      <= o0;
                        ovf       <= ovf_pend;
                        done_id   <= id_pend;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_sched.sv
// Directed self-checking bench for bcd_conv_sched. Expected digits are
// written as hand-computed BCD; blanking of leading zeros is applied to them
// when the bench is built with BCD_BLANK_EN.
module tb_bcd_conv_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req;
    logic [13:0] value0, value1;
    logic [1:0]  gnt;
    logic        busy, done, done_id, ovf;
    logic [3:0]  thousands, hundreds, tens, ones;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int t_done   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    bcd_conv_sched dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .value0    (value0),
        .value1    (value1),
        .gnt       (gnt),
        .busy      (busy),
        .done      (done),
        .done_id   (done_id),
        .thousands (thousands),
        .hundreds  (hundreds),
        .tens      (tens),
        .ones      (ones),
        .ovf       (ovf)
    );

    wire [15:0] digits = {thousands, hundreds, tens, ones};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Displayed form of a raw BCD value for the current build
    function automatic logic [15:0] disp(input logic [15:0] bcd);
        logic [15:0] r;
        r = bcd;
`ifdef BCD_BLANK_EN
        if (r[15:12] == 4'd0) begin
            r[15:12] = 4'hF;
            if (r[11:8] == 4'd0) begin
                r[11:8] = 4'hF;
                if (r[7:4] == 4'd0) r[7:4] = 4'hF;
            end
        end
`endif
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp_gnt);
        int n = 0;
        while (gnt == 2'b00 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_gnt"}, gnt, exp_gnt);
        check({tag, "_busy_on"}, busy, 1'b1);
    endtask

    task automatic wait_done(input string tag, input logic [15:0] exp_bcd,
                             input logic exp_id, input logic exp_ovf);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!done && n < 40);
        check({tag, "_latency"}, n, 14);
        check({tag, "_digits"}, digits, disp(exp_bcd));
        check({tag, "_id"}, done_id, exp_id);
        check({tag, "_ovf"}, ovf, exp_ovf);
        check({tag, "_busy_off"}, busy, 1'b0);
        t_done = cyc;
    endtask

    task automatic convert(input string tag, input logic src, input logic [13:0] val,
                           input logic [15:0] exp_bcd, input logic exp_ovf);
        if (src) begin
            value1 = val;
            req    = 2'b10;
        end else begin
            value0 = val;
            req    = 2'b01;
        end
        wait_gnt(tag, src ? 2'b10 : 2'b01);
        req = 2'b00;
        wait_done(tag, exp_bcd, src, exp_ovf);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 1'b0);
        check({tag, "_hold"}, digits, disp(exp_bcd));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int td_first;
        int seen;
        rst    = 1'b1;
        req    = 2'b00;
        value0 = '0;
        value1 = '0;
        #12;
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_id", done_id, 1'b0);
        check("rst_digits", digits, 16'h0000);
        check("rst_ovf", ovf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic conversion from source 0
        convert("v1234", 1'b0, 14'd1234, 16'h1234, 1'b0);

        // Both requesting after reset: source 0 first, source 1 right after done
        do_reset();
        value0 = 14'd0;
        value1 = 14'd9999;
        req    = 2'b11;
        wait_gnt("both_a", 2'b01);
        wait_done("both_a", 16'h0000, 1'b0, 1'b0);
        td_first = t_done;
        @(posedge clk); #1;
        check("both_b_gnt", gnt, 2'b10);
        req = 2'b00;
        wait_done("both_b", 16'h9999, 1'b1, 1'b0);
        check("done_spacing", t_done - td_first, 15);
        @(posedge clk); #1;

        // Clamp boundaries
        convert("v16383", 1'b0, 14'd16383, 16'h9999, 1'b1);
        convert("v10000", 1'b0, 14'd10000, 16'h9999, 1'b1);
        convert("v9999",  1'b0, 14'd9999,  16'h9999, 1'b0);

        // Leading-zero handling
        convert("v7",    1'b0, 14'd7,    16'h0007, 1'b0);
        convert("v0",    1'b0, 14'd0,    16'h0000, 1'b0);
        convert("v1005", 1'b0, 14'd1005, 16'h1005, 1'b0);

        // Reset in the 6th SHIFT cycle discards the conversion
        value0 = 14'd5678;
        req    = 2'b01;
        wait_gnt("mid", 2'b01);
        req = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_digits", digits, 16'h0000);
        check("mid_done", done, 1'b0);
        check("mid_gnt", gnt, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("mid_no_done", seen, 0);
        convert("v42", 1'b1, 14'd42, 16'h0042, 1'b0);

        // Round robin with both pending, then a lone requester
        value0 = 14'd111;
        value1 = 14'd222;
        req    = 2'b11;
        wait_gnt("rr0", 2'b01);
        wait_done("rr0", 16'h0111, 1'b0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("rr%0d_gnt", i), gnt, (i % 2 == 1) ? 2'b10 : 2'b01);
            if (i == 3) req = 2'b10;
            wait_done($sformatf("rr%0d", i), (i % 2 == 1) ? 16'h0222 : 16'h0111,
                      (i % 2 == 1), 1'b0);
        end
        @(posedge clk); #1;
        check("lone_gnt", gnt, 2'b10);
        req = 2'b11;
        wait_done("lone", 16'h0222, 1'b1, 1'b0);
        @(posedge clk); #1;
        check("rr_back_gnt", gnt, 2'b01);
        req = 2'b00;
        wait_done("rr_back", 16'h0111, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
